// File: rtl/uart_pkg.sv
// Shared UART definitions used by both uart_tx and uart_rx.
//   uart_state_t        : receiver FSM state encoding (also exported on debug ports)
//   uart_cycles_per_bit : clocks per bit from clock and baud rate, so both ends
//                         of the link derive the bit period the same way
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  function automatic int uart_cycles_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input pin.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output (two clocks of latency)
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing (start, LSB-first data, one stop, no parity).
//   i_clk       : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_rx        : asynchronous serial line, idle high
//   o_data      : last good word, held until the next good frame
//   o_valid     : one-cycle strobe, o_data is new this cycle
//   o_frame_err : one-cycle strobe, stop bit sampled low
//   o_busy      : FSM not in IDLE
//   o_state     : debug view of the FSM state (uart_state_t encoding)
//
// Handshake: o_valid is a pure strobe with no ready; the consumer must take
// o_data in the cycle o_valid is high. o_valid and o_frame_err never overlap.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = uart_cycles_per_bit(CLOCK_RATE, BAUD_RATE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  // Half-bit load lands the start-bit sample mid-bit; every later sample is a
  // full bit after the previous one, so all samples stay centred.
  localparam logic [CW-1:0] CNT_HALF = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  uart_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          // Line went back high by mid-bit: treat as a glitch.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          idx_d   = '0;
          cnt_d   = CNT_FULL;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == LAST_IDX) state_d = ST_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so a break yields a single error.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_state     = state_q;

endmodule
